// File: rtl/motion_sensor_conditioner_if.sv
// Sensor pin and conditioned motion outputs for the light controller front end.
interface motion_sensor_conditioner_if;
   logic sensor_raw;
   logic motion_detect;
   logic motion_pulse;
   logic sensor_fault;

   modport master (
      output sensor_raw,
      input  motion_detect,
      input  motion_pulse,
      input  sensor_fault
   );

   modport slave (
      input  sensor_raw,
      output motion_detect,
      output motion_pulse,
      output sensor_fault
   );
endinterface

// File: rtl/motion_sensor_conditioner.sv
// PIR synchroniser + asymmetric debouncer with motion strobe.
// Define MOTION_STUCK_EN to build the stuck-high sensor fault detector.
module motion_sensor_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int RISE_CYCLES = 1000,
   parameter int FALL_CYCLES = 10000,
   parameter int CLK_HZ      = 10000000,
   parameter int STUCK_SEC   = 3600
) (
   input  logic                         clk,
   input  logic                         rstn,
   motion_sensor_conditioner_if.slave   bus
);

   localparam int MAXC = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   typedef enum logic [1:0] {
      S_LOW,
      S_RISE,
      S_HIGH,
      S_FALL
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync_in;
   state_t                 r_state;
   state_t                 w_state_nx;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nx;
   logic                   r_md;
   logic                   r_pulse;
   logic                   w_md_nx;
   logic                   w_fault_nx;

   assign w_sync_in = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync  <= '0;
         r_state <= S_LOW;
         r_cnt   <= '0;
         r_md    <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.sensor_raw};
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_md    <= w_md_nx;
         r_pulse <= w_md_nx & ~r_md;
      end
   end

   // Aborts take priority over qualification on the terminal count.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
         S_LOW: begin
            if (w_sync_in) begin
               w_state_nx = S_RISE;
               w_cnt_nx   = CW'(1);
            end else begin
               w_cnt_nx   = '0;
            end
         end
         S_RISE: begin
            if (!w_sync_in) begin
               w_state_nx = S_LOW;
               w_cnt_nx   = '0;
            end else if (r_cnt == CW'(RISE_CYCLES - 1)) begin
               w_state_nx = S_HIGH;
            end else if (r_cnt != '1) begin
               w_cnt_nx   = r_cnt + CW'(1);
            end
         end
         S_HIGH: begin
            if (!w_sync_in) begin
               w_state_nx = S_FALL;
               w_cnt_nx   = CW'(1);
            end
         end
         S_FALL: begin
            if (w_sync_in) begin
               w_state_nx = S_HIGH;
               w_cnt_nx   = '0;
            end else if (r_cnt == CW'(FALL_CYCLES - 1)) begin
               w_state_nx = S_LOW;
            end else if (r_cnt != '1) begin
               w_cnt_nx   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nx = S_LOW;
            w_cnt_nx   = '0;
         end
      endcase
   end

`ifdef MOTION_STUCK_EN
   localparam int PW = $clog2(CLK_HZ) + 1;
   localparam int SW = $clog2(STUCK_SEC + 1) + 1;

   logic [PW-1:0] r_pre;
   logic [PW-1:0] w_pre_nx;
   logic [SW-1:0] r_sec;
   logic [SW-1:0] w_sec_nx;
   logic          r_fault;
   logic          w_tick;
   logic          w_active;

   assign w_active = (r_state == S_HIGH) || (r_state == S_FALL);

   // Time only accumulates while motion is qualified; fault holds until S_LOW.
   always_comb begin
      w_pre_nx = '0;
      w_sec_nx = '0;
      w_tick   = 1'b0;
      if (w_active) begin
         w_tick   = (r_pre == PW'(CLK_HZ - 1));
         w_pre_nx = w_tick ? '0 : r_pre + PW'(1);
         w_sec_nx = (w_tick && r_sec != SW'(STUCK_SEC)) ? r_sec + SW'(1) : r_sec;
      end
      if (w_state_nx == S_LOW)
         w_fault_nx = 1'b0;
      else
         w_fault_nx = r_fault | (w_sec_nx == SW'(STUCK_SEC));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pre   <= '0;
         r_sec   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_pre   <= w_pre_nx;
         r_sec   <= w_sec_nx;
         r_fault <= w_fault_nx;
      end
   end

   assign bus.sensor_fault = r_fault;
`else
   assign w_fault_nx       = 1'b0;
   assign bus.sensor_fault = 1'b0;
`endif

   assign w_md_nx = ((w_state_nx == S_HIGH) || (w_state_nx == S_FALL)) && !w_fault_nx;

   assign bus.motion_detect = r_md;
   assign bus.motion_pulse  = r_pulse;

endmodule

// File: tb/tb_motion_sensor_conditioner.sv
// Bench for motion_sensor_conditioner: vector table, directed corners, random runs.
module tb_motion_sensor_conditioner;

   localparam int SS  = 2;
   localparam int RC  = 4;
   localparam int FC  = 8;
   localparam int HZ  = 10;
   localparam int SEC = 3;
`ifdef MOTION_STUCK_EN
   localparam bit STUCK = 1'b1;
`else
   localparam bit STUCK = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_errs;

   motion_sensor_conditioner_if bus ();

   motion_sensor_conditioner #(
      .SYNC_STAGES (SS),
      .RISE_CYCLES (RC),
      .FALL_CYCLES (FC),
      .CLK_HZ      (HZ),
      .STUCK_SEC   (SEC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Reference: sync delay line, run length of equal sync samples, level hysteresis.
   bit m_sync [SS];
   bit m_last;
   int m_run;
   bit m_level;
   bit m_fault;
   bit m_md;
   bit m_pulse;
   int m_hcnt;

   function automatic void model_reset();
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      m_last  = 1'b0;
      m_run   = 0;
      m_level = 1'b0;
      m_fault = 1'b0;
      m_md    = 1'b0;
      m_pulse = 1'b0;
      m_hcnt  = 0;
   endfunction

   function automatic void model_edge(bit raw);
      bit sin;
      bit was;
      bit md_old;
      sin    = m_sync[SS-1];
      was    = m_level;
      md_old = m_md;
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = raw;
      if (sin == m_last) begin
         m_run = m_run + 1;
      end else begin
         m_run  = 1;
         m_last = sin;
      end
      if (!m_level && sin && m_run >= RC) m_level = 1'b1;
      else if (m_level && !sin && m_run >= FC) m_level = 1'b0;
      if (STUCK) begin
         m_hcnt  = was ? m_hcnt + 1 : 0;
         m_fault = m_level ? (m_fault || m_hcnt >= HZ * SEC) : 1'b0;
      end
      m_md    = m_level && !m_fault;
      m_pulse = m_md && !md_old;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive raw for one cycle, advance the model, compare just after the edge.
   task automatic step(input bit raw);
      bus.sensor_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      check("model_md", bus.motion_detect, m_md);
      check("model_pulse", bus.motion_pulse, m_pulse);
      check("model_fault", bus.sensor_fault, m_fault);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   typedef struct {
      bit raw;
      bit md;
      bit pulse;
   } vec_t;

   vec_t tv [8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  drop;
      int  rise;
      int  fedge;
      int  npulse;
      bit  saw;
      bit  held;
      bit  v;
      int  len;

      n_checks = 0;
      n_errs   = 0;
      for (int i = 0; i < 8; i++) begin
         tv[i].raw   = 1'b1;
         tv[i].md    = (i >= 5);
         tv[i].pulse = (i == 5);
      end

      // Reset held with raw high
      bus.sensor_raw = 1'b1;
      rstn = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_md", bus.motion_detect, 1'b0);
      check("rst_pulse", bus.motion_pulse, 1'b0);
      check("rst_fault", bus.sensor_fault, 1'b0);
      rstn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         step(tv[i].raw);
         check($sformatf("tv%0d_md", i), bus.motion_detect, tv[i].md);
         check($sformatf("tv%0d_pulse", i), bus.motion_pulse, tv[i].pulse);
      end

      // Bounce from idle
      for (int i = 0; i < 12; i++) step(1'b0);
      saw = 1'b0;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 3; i++) begin
            step(1'b1);
            saw |= bus.motion_detect | bus.motion_pulse;
         end
         for (int i = 0; i < 3; i++) begin
            step(1'b0);
            saw |= bus.motion_detect | bus.motion_pulse;
         end
      end
      check("bounce_quiet", saw, 1'b0);

      // Hold-off: 7-cycle gap keeps motion, 8-cycle gap drops it
      for (int i = 0; i < 8; i++) step(1'b1);
      held = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(1'b0);
         held &= bus.motion_detect;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         held &= bus.motion_detect;
      end
      check("holdoff_held", held, 1'b1);
      drop = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0);
         if (!bus.motion_detect && drop == 0) drop = i;
      end
      check_int("fall_latency", drop, 10);

      // Async reset mid-fall
      for (int i = 0; i < 8; i++) step(1'b1);
      for (int i = 0; i < 4; i++) step(1'b0);
      check("pre_arst_md", bus.motion_detect, 1'b1);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_md", bus.motion_detect, 1'b0);
      check("arst_pulse", bus.motion_pulse, 1'b0);
      check("arst_fault", bus.sensor_fault, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      rise = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1'b1);
         if (bus.motion_detect && rise == 0) rise = i;
      end
      check_int("arst_rise_latency", rise, 6);

      // Stuck sensor
      for (int i = 0; i < 12; i++) step(1'b0);
      rise  = 0;
      fedge = 0;
      for (int i = 1; i <= 45; i++) begin
         step(1'b1);
         if (bus.motion_detect && rise == 0) rise = i;
         if (bus.sensor_fault && fedge == 0) fedge = i;
      end
      check_int("stuck_rise", rise, 6);
      check_int("stuck_fault_edge", fedge, STUCK ? 36 : 0);
      check("stuck_md", bus.motion_detect, !STUCK);
      check("stuck_fault", bus.sensor_fault, STUCK);
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         npulse += int'(bus.motion_pulse);
      end
      check("stuck_clear_fault", bus.sensor_fault, 1'b0);
      check_int("stuck_clear_pulses", npulse, 0);

      // Random runs of random length
      do_reset();
      for (int r = 0; r < 300; r++) begin
         v   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
         for (int i = 0; i < len; i++) step(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
